// File: rtl/nochange_ram_initiator_pkg.sv
// Shared types and helpers for the no-change RAM initiator.
// READ_LATENCY follows the RAM's output-register option.
package nochange_ram_initiator_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam int PERF_W = 8 * 16;

    function automatic int read_latency(input logic [PERF_W-1:0] perf);
        return (perf == PERF_W'("LOW_LATENCY")) ? 1 : 2;
    endfunction

endpackage

// File: rtl/nochange_ram_rsp_fifo.sv
// Response buffer: synchronous FIFO with occupancy count.
// Storage is reset so the head reads as zero after reset.
module nochange_ram_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clka,
    input  logic                         rsta_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nochange_ram_initiator.sv
// Drives a single-port no-change RAM for a valid/ready client, with an
// optional post-reset zeroing sweep and credit-limited in-order read returns.
module nochange_ram_initiator
    import nochange_ram_initiator_pkg::*;
#(
    parameter int                RAM_WIDTH       = 8,
    parameter int                RAM_DEPTH       = 256,
    parameter logic [PERF_W-1:0] RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter int                RSP_DEPTH       = 4,
    parameter int                CLEAR_ON_RESET  = 0,
    localparam int               ADDR_W          = $clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic                 rsta_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [RAM_WIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RAM_WIDTH-1:0] rsp_rdata,
    output logic                 busy,
    output logic [ADDR_W-1:0]    addra,
    output logic [RAM_WIDTH-1:0] dina,
    output logic                 wea,
    output logic                 ena,
    output logic                 rsta,
    output logic                 regcea,
    input  logic [RAM_WIDTH-1:0] douta
);
    localparam int     READ_LATENCY = read_latency(RAM_PERFORMANCE);
    localparam int     CNT_W        = $clog2(RSP_DEPTH + 1);
    localparam state_t RST_STATE    = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t                state, state_next;
    logic [ADDR_W-1:0]     clr_addr;
    logic [READ_LATENCY:0] vld_pipe;
    logic [CNT_W-1:0]      inflight, occupancy, credits;
    logic                  req_acc, rd_acc, rsp_pop, fifo_empty;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) state <= RST_STATE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy = 1'b1;
                if (clr_addr == ADDR_W'(RAM_DEPTH - 1)) state_next = ST_RUN;
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = RST_STATE;
        endcase
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n)               clr_addr <= '0;
        else if (state == ST_CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
    end

    // A read holds its credit from acceptance until the client pops it.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= READ_LATENCY; i++) inflight = inflight + CNT_W'(vld_pipe[i]);
    end

    assign credits   = CNT_W'(RSP_DEPTH) - inflight - occupancy;
    assign rsp_valid = !fifo_empty;
    assign rsp_pop   = rsp_valid && rsp_ready;
    // A credit returned by this cycle's pop can be reused by this cycle's accept.
    assign req_ready = (state == ST_RUN) && ((credits != '0) || rsp_pop);
    assign req_acc   = req_valid && req_ready;
    assign rd_acc    = req_acc && !req_we;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            ena   <= 1'b0;
            wea   <= 1'b0;
            addra <= '0;
            dina  <= '0;
        end else if (state == ST_CLEAR) begin
            ena   <= 1'b1;
            wea   <= 1'b1;
            addra <= clr_addr;
            dina  <= '0;
        end else if (req_acc) begin
            ena   <= 1'b1;
            wea   <= req_we;
            addra <= req_addr;
            dina  <= req_wdata;
        end else begin
            ena   <= 1'b0;
            wea   <= 1'b0;
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) rsta <= 1'b1;
        else         rsta <= (state_next == ST_CLEAR);
    end

    // Bit 0 marks a read's ena cycle; the top bit is its capture cycle.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) vld_pipe <= '0;
        else         vld_pipe <= {vld_pipe[READ_LATENCY-1:0], rd_acc};
    end

    if (READ_LATENCY == 2) begin : g_oreg
        assign regcea = vld_pipe[1];
    end else begin : g_no_oreg
        assign regcea = 1'b0;
    end

    nochange_ram_rsp_fifo #(
        .WIDTH(RAM_WIDTH),
        .DEPTH(RSP_DEPTH)
    ) u_rsp_fifo (
        .clka  (clka),
        .rsta_n(rsta_n),
        .push  (vld_pipe[READ_LATENCY]),
        .din   (douta),
        .pop   (rsp_pop),
        .dout  (rsp_rdata),
        .empty (fifo_empty),
        .count (occupancy)
    );

endmodule
